// File: rtl/spi_sck_gen_pkg.sv
// Shared definitions for the SPI serial-clock generator: state encoding and
// default widths for the baud divider and frame-length fields.
package spi_sck_gen_pkg;

    localparam int DIV_W_DEFAULT = 8;
    localparam int LEN_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_TRAIL = 2'd3
    } state_e;

endpackage

// File: rtl/spi_baud_tick.sv
// Half-period tick counter: tick is high for one cycle every div+1 cycles while
// clr is low; the count reloads on each tick so it never wraps.
module spi_baud_tick
    import spi_sck_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick = !clr && (cnt_q == div);

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sck_gen.sv
// SPI master clock/framing generator: produces SCK, slave select and the
// shift/sample enables for one frame, all as clk-synchronous registered outputs.
module spi_sck_gen
    import spi_sck_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [DIV_W-1:0] div,
    input  logic [LEN_W-1:0] len,
    output logic             sck_out,
    output logic             ss_n,
    output logic             shift_en,
    output logic             sample_en,
    output logic             busy,
    output logic             done
);

    localparam int EDGE_W = LEN_W + 2;

    state_e             state_q, state_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic               sck_q, sck_d;
    logic               shift_q, shift_d;
    logic               sample_q, sample_d;
    logic               done_q, done_d;

    logic               tick;
    logic               tick_clr;
    logic [LEN_W:0]     len_p1;
    logic [EDGE_W-1:0]  edge_total;
    logic [EDGE_W-1:0]  edge_n;
    logic               edge_shift;
    logic               edge_sample;

    assign tick_clr = (state_q == ST_IDLE) || abort;

    spi_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .div   (div_q),
        .tick  (tick)
    );

    // Toggle n is applied when edge_q steps to n; odd toggles are leading edges.
    assign len_p1      = {1'b0, len_q} + (LEN_W + 1)'(1);
    assign edge_total  = {len_p1, 1'b0};
    assign edge_n      = edge_q + EDGE_W'(1);
    assign edge_shift  = edge_n[0] ? cpha_q : (!cpha_q && (edge_n != edge_total));
    assign edge_sample = edge_n[0] ? !cpha_q : cpha_q;

    always_comb begin
        state_d  = state_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        div_d    = div_q;
        len_d    = len_q;
        edge_d   = edge_q;
        sck_d    = sck_q;
        shift_d  = 1'b0;
        sample_d = 1'b0;
        done_d   = 1'b0;

        if (state_q == ST_IDLE) begin
            sck_d = cpol;
            if (start) begin
                cpol_d  = cpol;
                cpha_d  = cpha;
                div_d   = div;
                len_d   = len;
                edge_d  = '0;
                shift_d = !cpha;
                state_d = ST_LEAD;
            end
        end else if (abort) begin
            state_d = ST_IDLE;
            sck_d   = cpol_q;
            edge_d  = '0;
        end else if (tick) begin
            case (state_q)
                ST_LEAD: begin
                    state_d  = ST_RUN;
                    sck_d    = !sck_q;
                    edge_d   = edge_n;
                    shift_d  = edge_shift;
                    sample_d = edge_sample;
                end
                ST_RUN: begin
                    if (edge_q == edge_total) begin
                        state_d = ST_TRAIL;
                    end else begin
                        sck_d    = !sck_q;
                        edge_d   = edge_n;
                        shift_d  = edge_shift;
                        sample_d = edge_sample;
                    end
                end
                ST_TRAIL: begin
                    state_d = ST_IDLE;
                    edge_d  = '0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            len_q    <= '0;
            edge_q   <= '0;
            sck_q    <= 1'b0;
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            div_q    <= div_d;
            len_q    <= len_d;
            edge_q   <= edge_d;
            sck_q    <= sck_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    assign sck_out   = sck_q;
    assign shift_en  = shift_q;
    assign sample_en = sample_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign ss_n      = !busy;

endmodule

// File: tb/tb_spi_sck_gen.sv
// Directed bench for spi_sck_gen: per-frame event counts (toggles, strobes by
// SCK direction, busy cycles, done pulses) compared with hand-computed values.
module tb_spi_sck_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    logic [4:0] len;
    logic       sck_out;
    logic       ss_n;
    logic       shift_en;
    logic       sample_en;
    logic       busy;
    logic       done;

    spi_sck_gen #(
        .DIV_W (8),
        .LEN_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cpol      (cpol),
        .cpha      (cpha),
        .div       (div),
        .len       (len),
        .sck_out   (sck_out),
        .ss_n      (ss_n),
        .shift_en  (shift_en),
        .sample_en (sample_en),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int C_TOG    = 0;
    localparam int C_SHIFT  = 1;
    localparam int C_SAMP   = 2;
    localparam int C_BUSY   = 3;
    localparam int C_DONE   = 4;
    localparam int C_SARISE = 5;
    localparam int C_SHFALL = 6;
    localparam int C_SHRISE = 7;
    localparam int C_SAFALL = 8;

    int n_vec = 0;
    int n_mis = 0;
    int cnt [9];
    int base[9];
    int gap_min, gap_max;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Event monitor, sampling on the falling edge.
    initial begin
        int   cyc;
        int   last_tog;
        logic prev_sck;
        logic prev_busy;
        logic rise, fall;
        cyc = 0; last_tog = -1; prev_sck = 1'b0; prev_busy = 1'b0;
        gap_min = 0; gap_max = 0;
        for (int i = 0; i < 9; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            rise = (prev_sck == 1'b0) && (sck_out == 1'b1);
            fall = (prev_sck == 1'b1) && (sck_out == 1'b0);
            if (busy && !prev_busy) begin
                gap_min = 1000000; gap_max = 0; last_tog = -1;
            end
            if (busy && (rise || fall)) begin
                cnt[C_TOG]++;
                if (last_tog >= 0) begin
                    if (cyc - last_tog < gap_min) gap_min = cyc - last_tog;
                    if (cyc - last_tog > gap_max) gap_max = cyc - last_tog;
                end
                last_tog = cyc;
            end
            if (shift_en)          cnt[C_SHIFT]++;
            if (sample_en)         cnt[C_SAMP]++;
            if (busy)              cnt[C_BUSY]++;
            if (done)              cnt[C_DONE]++;
            if (sample_en && rise) cnt[C_SARISE]++;
            if (shift_en && fall)  cnt[C_SHFALL]++;
            if (shift_en && rise)  cnt[C_SHRISE]++;
            if (sample_en && fall) cnt[C_SAFALL]++;
            prev_sck  = sck_out;
            prev_busy = busy;
        end
    end

    task automatic snap();
        for (int i = 0; i < 9; i++) base[i] = cnt[i];
    endtask

    function automatic int delta(input int idx);
        return cnt[idx] - base[idx];
    endfunction

    // Called just before a falling edge-aligned drive point; drives config and
    // start, snapshots counters, and returns at the first LEAD-cycle negedge.
    task automatic launch(input logic p_cpol, input logic p_cpha,
                          input logic [7:0] p_div, input logic [4:0] p_len);
        cpol = p_cpol; cpha = p_cpha; div = p_div; len = p_len; start = 1'b1;
        #1 snap();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check_val("idle_reached", int'(busy), 0);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cpol = 1'b1; cpha = 1'b0; div = 8'd0; len = 5'd0;

        // Reset values while held in reset, with cpol=1 on the input.
        repeat (2) @(negedge clk);
        check_val("rst_sck", int'(sck_out), 0);
        check_val("rst_ssn", int'(ss_n), 1);
        check_val("rst_shift", int'(shift_en), 0);
        check_val("rst_sample", int'(sample_en), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        cpol = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, div=0, len=7.
        launch(1'b0, 1'b0, 8'd0, 5'd7);
        check_val("m0_lead_shift", int'(shift_en), 1);
        check_val("m0_lead_ssn", int'(ss_n), 0);
        check_val("m0_lead_sck", int'(sck_out), 0);
        wait_idle(100);
        check_val("m0_tog", delta(C_TOG), 16);
        check_val("m0_shift", delta(C_SHIFT), 8);
        check_val("m0_sample", delta(C_SAMP), 8);
        check_val("m0_sample_rise", delta(C_SARISE), 8);
        check_val("m0_shift_fall", delta(C_SHFALL), 7);
        check_val("m0_busy", delta(C_BUSY), 18);
        check_val("m0_done", delta(C_DONE), 1);
        check_val("m0_gap", gap_max, 1);

        // Idle SCK follows live cpol one cycle later.
        @(negedge clk);
        cpol = 1'b1;
        @(negedge clk);
        check_val("idle_cpol_hi", int'(sck_out), 1);

        // Mode 3, div=3, len=7.
        launch(1'b1, 1'b1, 8'd3, 5'd7);
        check_val("m3_lead_sck", int'(sck_out), 1);
        wait_idle(200);
        check_val("m3_tog", delta(C_TOG), 16);
        check_val("m3_shift_fall", delta(C_SHFALL), 8);
        check_val("m3_sample_rise", delta(C_SARISE), 8);
        check_val("m3_shift", delta(C_SHIFT), 8);
        check_val("m3_sample", delta(C_SAMP), 8);
        check_val("m3_busy", delta(C_BUSY), 72);
        check_val("m3_gap_min", gap_min, 4);
        check_val("m3_gap_max", gap_max, 4);
        check_val("m3_done", delta(C_DONE), 1);
        check_val("m3_idle_sck", int'(sck_out), 1);

        // Start during RUN is ignored and not queued.
        @(negedge clk);
        launch(1'b0, 1'b0, 8'd1, 5'd3);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(100);
        check_val("ign_busy", delta(C_BUSY), 20);
        check_val("ign_done", delta(C_DONE), 1);
        repeat (3) @(negedge clk);
        check_val("ign_not_queued", int'(busy), 0);

        // Back-to-back: start in the done cycle is accepted.
        @(negedge clk);
        launch(1'b0, 1'b0, 8'd1, 5'd3);
        wait_idle(100);
        check_val("b2b_done_now", int'(done), 1);
        launch(1'b0, 1'b0, 8'd1, 5'd3);
        check_val("b2b_accepted", int'(busy), 1);
        wait_idle(100);
        check_val("b2b_busy", delta(C_BUSY), 20);
        check_val("b2b_done", delta(C_DONE), 1);

        // Abort at the 5th toggle.
        @(negedge clk);
        launch(1'b0, 1'b0, 8'd2, 5'd7);
        for (int i = 0; i < 200; i++) begin
            if (delta(C_TOG) >= 5) break;
            @(negedge clk);
            #1;
        end
        check_val("ab_tog", delta(C_TOG), 5);
        check_val("ab_sck_before", int'(sck_out), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("ab_ssn", int'(ss_n), 1);
        check_val("ab_sck", int'(sck_out), 0);
        check_val("ab_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        #1;
        check_val("ab_no_done", delta(C_DONE), 0);
        launch(1'b0, 1'b0, 8'd0, 5'd7);
        wait_idle(100);
        check_val("ab_next_tog", delta(C_TOG), 16);
        check_val("ab_next_busy", delta(C_BUSY), 18);
        check_val("ab_next_done", delta(C_DONE), 1);

        // Reset mid-frame with len=31, div=255.
        @(negedge clk);
        launch(1'b1, 1'b0, 8'd255, 5'd31);
        repeat (600) @(negedge clk);
        check_val("mr_busy_before", int'(busy), 1);
        check_val("mr_sck_before", int'(sck_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("mr_sck", int'(sck_out), 0);
        check_val("mr_ssn", int'(ss_n), 1);
        check_val("mr_busy", int'(busy), 0);
        check_val("mr_strobes", int'(shift_en) + int'(sample_en), 0);
        repeat (2) @(negedge clk);
        #1;
        check_val("mr_no_done", delta(C_DONE), 0);

        // Release with start already high; len=0 boundary frame.
        cpol = 1'b0; cpha = 1'b0; div = 8'd0; len = 5'd0; start = 1'b1;
        rst_n = 1'b1;
        #1 snap();
        @(negedge clk);
        start = 1'b0;
        check_val("rel_first_edge", int'(busy), 1);
        wait_idle(50);
        check_val("l0_tog", delta(C_TOG), 2);
        check_val("l0_shift", delta(C_SHIFT), 1);
        check_val("l0_sample", delta(C_SAMP), 1);
        check_val("l0_sample_rise", delta(C_SARISE), 1);
        check_val("l0_busy", delta(C_BUSY), 4);
        check_val("l0_done", delta(C_DONE), 1);

        // Config inputs changed while busy have no effect.
        @(negedge clk);
        launch(1'b0, 1'b1, 8'd1, 5'd1);
        cpol = 1'b1; cpha = 1'b0; div = 8'd5; len = 5'd9;
        wait_idle(100);
        check_val("cf_busy", delta(C_BUSY), 12);
        check_val("cf_tog", delta(C_TOG), 4);
        check_val("cf_shift_rise", delta(C_SHRISE), 2);
        check_val("cf_sample_fall", delta(C_SAFALL), 2);
        check_val("cf_gap_min", gap_min, 2);
        check_val("cf_gap_max", gap_max, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/spi_sck_gen.md
SPI_SCK_GEN -- requirements
Module: spi_sck_gen

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, meaning the width of the baud divider.
REQ-002 The block SHALL have parameter LEN_W, default 5, meaning the width of the frame-length field (frames of up to 2^LEN_W bits).
REQ-003 The block SHALL have these ports:
- clk  input  1  system clock; one clock, all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  frame request; sampled only in IDLE.
- abort  input  1  synchronous frame abort.
- cpol  input  1  SCK idle level.
- cpha  input  1  0: sample on leading edge; 1: shift on leading edge.
- div  input  DIV_W  SCK half-period in clk cycles, minus 1.
- len  input  LEN_W  frame bit count, minus 1.
- sck_out  output  1  SPI serial clock.
- ss_n  output  1  slave select, active low.
- shift_en  output  1  one-cycle strobe: present next bit.
- sample_en  output  1  one-cycle strobe: capture input bit.
- busy  output  1  frame in progress.
- done  output  1  one-cycle frame-complete pulse.

Function
REQ-004 The block SHALL derive all SCK timing from clk through a half-period tick counter; it SHALL NOT generate derived clocks, and all strobes SHALL be clk-synchronous enables.
REQ-005 The block SHALL use states IDLE, LEAD, RUN and TRAIL.
REQ-006 In IDLE, start=1 SHALL latch cpol, cpha, div and len, clear the edge counter, and move to LEAD; latched values SHALL stay fixed until the block returns to IDLE.
REQ-007 LEAD SHALL last div+1 cycles with ss_n=0 and sck_out at the latched cpol level, then move to RUN.
REQ-008 RUN SHALL toggle sck_out once every div+1 cycles, for exactly 2*(len+1) toggles, then move to TRAIL.
REQ-009 Edge strobes SHALL be asserted in the same cycle that sck_out first shows the new level:
- Leading edges (toggles 1, 3, 5, ...): sample_en if cpha=0, shift_en if cpha=1.
- Trailing edges (toggles 2, 4, ...): shift_en if cpha=0, except the final trailing edge; sample_en if cpha=1.
REQ-010 For cpha=0, shift_en SHALL additionally pulse in the first LEAD cycle to present bit 0.
REQ-011 Every frame SHALL produce exactly len+1 shift_en pulses and len+1 sample_en pulses.
REQ-012 TRAIL SHALL last div+1 cycles with sck_out at cpol, then return to IDLE.
REQ-013 On the return to IDLE, the block SHALL pulse done for that one cycle and set ss_n=1 and busy=0.
REQ-014 busy SHALL be 1 in every LEAD, RUN and TRAIL cycle, and 0 otherwise.
REQ-015 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-016 div=0 SHALL give a one-cycle half-period (SCK = clk/2).
REQ-017 div at all-ones SHALL give a 2^DIV_W-cycle half-period.
REQ-018 The divider counter SHALL NOT wrap.
REQ-019 abort=1 in LEAD, RUN or TRAIL SHALL force IDLE on the next edge with ss_n=1, sck_out=cpol, and no done pulse; abort in IDLE SHALL be ignored.
REQ-020 If start and abort are both 1 in IDLE, start SHALL win.
REQ-021 In IDLE, sck_out SHALL follow the live cpol input, registered with one cycle of latency.

Reset
REQ-022 While rst_n=0, the block SHALL hold state IDLE with:
- sck_out=0
- ss_n=1
- shift_en=0
- sample_en=0
- busy=0
- done=0
- all counters cleared.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately and asynchronously, with no done pulse.
REQ-024 After reset release, the block SHALL accept start on the first clk edge.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE, LEAD, RUN, TRAIL) and the default values of DIV_W and LEN_W.
REQ-026 The half-period divider SHALL be a single sub-module, spi_baud_tick (parameter DIV_W; inputs clk, rst_n, clr, div; output tick), instantiated once.

Verification
REQ-027 Mode 0 (cpol=0, cpha=0, div=0, len=7), start pulse -> 16 sck toggles, 8 sample_en on rising edges, 8 shift_en (LEAD cycle plus 7 falling edges), done after 18 busy cycles.
REQ-028 Mode 3 (cpol=1, cpha=1, div=3, len=7) -> sck idles high, half-period of 4 cycles, shift_en on falling edges, sample_en on rising edges, busy for 72 cycles.
REQ-029 start asserted during RUN -> ignored; exactly one done pulse; a new start accepted in the IDLE cycle after done.
REQ-030 abort at the 5th sck toggle -> ss_n=1 and sck_out=cpol next cycle; no done pulse; subsequent frame normal.
REQ-031 rst_n=0 mid-frame (len=31, div=255) -> outputs at reset values asynchronously; first frame after release is correct.
REQ-032 Boundary: len=0 -> exactly 2 toggles, 1 shift_en, 1 sample_en; cpol/div changed while busy -> no effect on the current frame.
